// File: rtl/hl_accum_pkg.sv
// ---------------------------------------------------------------------------
// hl_accum_pkg
//
// Shared types and arithmetic for the hidden-layer accumulator.
//   state_e   : pass state (IDLE -> ACCUM -> HOLD -> IDLE).
//   sat_add   : adds an addend to a signed accumulator of a given width and
//               reports whether the result left that width's signed range.
//               On overflow it returns either the clamped value (saturate=1)
//               or the two's-complement wrapped value (saturate=0).
//   ACC_MAX / ACC_MIN : signed limits of the default 32-bit accumulator.
//
// Arithmetic is done at MATH_WIDTH bits, so any accumulator width from 2 up
// to MATH_WIDTH-1 can use sat_add without the sum itself overflowing.
// ---------------------------------------------------------------------------
package hl_accum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam int MATH_WIDTH    = 64;
  localparam int DEF_ACC_WIDTH = 32;

  localparam logic signed [MATH_WIDTH-1:0] ACC_MAX =
    (64'sd1 <<< (DEF_ACC_WIDTH - 1)) - 64'sd1;
  localparam logic signed [MATH_WIDTH-1:0] ACC_MIN =
    -(64'sd1 <<< (DEF_ACC_WIDTH - 1));

  // Result of one accumulate step. sum is the accumulator value in the low
  // 'width' bits, sign-extended to MATH_WIDTH.
  typedef struct packed {
    logic [MATH_WIDTH-1:0] sum;
    logic                  ovf;
  } sat_sum_t;

  function automatic logic signed [MATH_WIDTH-1:0] acc_max(input int width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [MATH_WIDTH-1:0] acc_min(input int width);
    return -(64'sd1 <<< (width - 1));
  endfunction

  function automatic sat_sum_t sat_add(
    input logic signed [MATH_WIDTH-1:0] acc,
    input logic signed [MATH_WIDTH-1:0] addend,
    input int                           width,
    input logic                         saturate
  );
    sat_sum_t                    res;
    logic signed [MATH_WIDTH-1:0] raw;
    logic signed [MATH_WIDTH-1:0] hi;
    logic signed [MATH_WIDTH-1:0] lo;
    logic signed [MATH_WIDTH-1:0] shifted;
    int unsigned                 sh;

    raw = acc + addend;
    hi  = acc_max(width);
    lo  = acc_min(width);
    res.ovf = (raw > hi) || (raw < lo);

    // Wrapped value: keep the low 'width' bits and sign-extend them by
    // shifting up to the top of the word and arithmetically back down.
    sh      = int'(MATH_WIDTH - width);
    shifted = raw <<< sh;
    res.sum = shifted >>> sh;

    if (res.ovf && saturate) begin
      res.sum = (raw > hi) ? hi : lo;
    end
    return res;
  endfunction

endpackage : hl_accum_pkg

// File: rtl/hidden_layer_accum_lane.sv
// ---------------------------------------------------------------------------
// accum_lane
//
// One neuron's accumulator. On each enabled cycle it adds the sign-extended
// weight when x=1 (zero when x=0), saturating or wrapping on overflow, and
// keeps a sticky overflow flag.
//
// Ports
//   Clk    in   clock
//   RST    in   synchronous active-high reset (clears acc and ovf)
//   clear  in   start-of-pass clear (same effect as RST)
//   en     in   a beat was accepted this cycle
//   x      in   binary activation of the beat
//   w_i    in   signed weight for this lane
//   acc    out  registered signed accumulator
//   ovf    out  sticky overflow flag
// ---------------------------------------------------------------------------
module accum_lane
  import hl_accum_pkg::*;
#(
  parameter int W_WIDTH   = 8,
  parameter int ACC_WIDTH = 32,
  parameter int SATURATE  = 1
) (
  input  logic                 Clk,
  input  logic                 RST,
  input  logic                 clear,
  input  logic                 en,
  input  logic                 x,
  input  logic [W_WIDTH-1:0]   w_i,
  output logic [ACC_WIDTH-1:0] acc,
  output logic                 ovf
);

  logic signed [MATH_WIDTH-1:0] acc_ext;
  logic signed [MATH_WIDTH-1:0] addend;
  sat_sum_t                     step;
  logic                         sum_hi_unused;

  always_comb begin
    acc_ext = {{(MATH_WIDTH - ACC_WIDTH){acc[ACC_WIDTH-1]}}, acc};
    addend  = '0;
    if (x) begin
      addend = {{(MATH_WIDTH - W_WIDTH){w_i[W_WIDTH-1]}}, w_i};
    end
    step = sat_add(acc_ext, addend, ACC_WIDTH, SATURATE != 0);
  end

  // The upper bits of the step result are only a sign extension of the
  // lane value and are not stored.
  assign sum_hi_unused = ^step.sum[MATH_WIDTH-1:ACC_WIDTH];

  always_ff @(posedge Clk) begin
    if (RST || clear) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (en) begin
      acc <= step.sum[ACC_WIDTH-1:0];
      ovf <= ovf | step.ovf;
    end
  end

endmodule : accum_lane

// File: rtl/hidden_layer_accum.sv
// ---------------------------------------------------------------------------
// hidden_layer_accum
//
// N_NEURONS parallel accumulators fed by a stream of N_INPUTS binary
// activations. A pass is started with Start in IDLE, accepts exactly
// N_INPUTS beats through a valid/ready handshake, and then holds the
// finished sums on Z with ZValid until the consumer asserts ZReady.
//
// Ports
//   Clk       in   clock, all state changes on posedge
//   RST       in   synchronous active-high reset, overrides everything
//   Start     in   begin a pass (sampled only in IDLE)
//   InValid   in   x and w are valid this cycle
//   InReady   out  high only while accumulating
//   x         in   binary activation for the beat
//   w         in   lane weights, lane i at [i*W_WIDTH +: W_WIDTH]
//   Z         out  registered lane sums, lane i at [i*ACC_WIDTH +: ACC_WIDTH]
//   ZValid    out  Z holds a completed pass
//   ZReady    in   consumer takes the result
//   Busy      out  state is not IDLE
//   Overflow  out  sticky per-lane overflow flags
//
// ACC_WIDTH must lie in [W_WIDTH+1, 63]; N_INPUTS must be at least 1.
// ---------------------------------------------------------------------------
module hidden_layer_accum
  import hl_accum_pkg::*;
#(
  parameter int N_NEURONS = 4,
  parameter int W_WIDTH   = 8,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int N_INPUTS  = 16,
  parameter int SATURATE  = 1
) (
  input  logic                           Clk,
  input  logic                           RST,
  input  logic                           Start,
  input  logic                           InValid,
  output logic                           InReady,
  input  logic                           x,
  input  logic [N_NEURONS*W_WIDTH-1:0]   w,
  output logic [N_NEURONS*ACC_WIDTH-1:0] Z,
  output logic                           ZValid,
  input  logic                           ZReady,
  output logic                           Busy,
  output logic [N_NEURONS-1:0]           Overflow
);

  localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_INPUTS - 1);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_ACCUM = ACCUM;
  localparam logic [1:0] ST_HOLD  = HOLD;

  logic [1:0]       state_reg;
  logic [1:0]       state_next;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             accept;
  logic             clear;
  logic             last_beat;

  // A beat is taken only while accumulating; Start only matters in IDLE.
  assign accept    = (state_reg == ST_ACCUM) && InValid;
  assign clear     = (state_reg == ST_IDLE) && Start;
  assign last_beat = (count_reg == LAST_BEAT);

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    case (state_reg)
      ST_IDLE: begin
        if (Start) begin
          state_next = ST_ACCUM;
          count_next = '0;
        end
      end
      ST_ACCUM: begin
        if (accept) begin
          if (last_beat) begin
            state_next = ST_HOLD;
            count_next = '0;
          end else begin
            count_next = count_reg + 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (ZReady) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        count_next = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (RST) begin
      state_reg <= ST_IDLE;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  assign InReady = (state_reg == ST_ACCUM);
  assign ZValid  = (state_reg == ST_HOLD);
  assign Busy    = (state_reg != ST_IDLE);

  // Lanes drive their slices of Z and Overflow directly, so Z is frozen
  // whenever no beat is accepted (HOLD, IDLE, or InValid low).
  for (genvar gi = 0; gi < N_NEURONS; gi++) begin : g_lane
    accum_lane #(
      .W_WIDTH  (W_WIDTH),
      .ACC_WIDTH(ACC_WIDTH),
      .SATURATE (SATURATE)
    ) u_lane (
      .Clk  (Clk),
      .RST  (RST),
      .clear(clear),
      .en   (accept),
      .x    (x),
      .w_i  (w[gi*W_WIDTH +: W_WIDTH]),
      .acc  (Z[gi*ACC_WIDTH +: ACC_WIDTH]),
      .ovf  (Overflow[gi])
    );
  end

endmodule : hidden_layer_accum

// File: tb/tb_hidden_layer_accum.sv
// ---------------------------------------------------------------------------
// tb_hidden_layer_accum
//
// Three instances share one input stream: default 32-bit saturating lanes,
// 9-bit saturating lanes and 9-bit wrapping lanes. Table rows carry
// hand-derived sums for all three; random passes are checked against a
// behavioural model computed from the accepted beats.
// ---------------------------------------------------------------------------
module tb_hidden_layer_accum;

  localparam int NN  = 4;
  localparam int WW  = 8;
  localparam int NI  = 16;
  localparam int AW  = 32;
  localparam int AWS = 9;

  logic Clk = 1'b0;
  logic RST, Start, InValid, x, ZReady;
  logic [NN*WW-1:0]  w;
  logic [NN*AW-1:0]  z_def;
  logic [NN*AWS-1:0] z_sat, z_wrap;
  logic in_ready_def, in_ready_sat, in_ready_wrap;
  logic zv_def, zv_sat, zv_wrap;
  logic busy_def, busy_sat, busy_wrap;
  logic [NN-1:0] ovf_def, ovf_sat, ovf_wrap;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 Clk = ~Clk;

  hidden_layer_accum u_def (
    .Clk(Clk), .RST(RST), .Start(Start), .InValid(InValid), .InReady(in_ready_def),
    .x(x), .w(w), .Z(z_def), .ZValid(zv_def), .ZReady(ZReady), .Busy(busy_def),
    .Overflow(ovf_def)
  );

  hidden_layer_accum #(.ACC_WIDTH(AWS), .SATURATE(1)) u_sat (
    .Clk(Clk), .RST(RST), .Start(Start), .InValid(InValid), .InReady(in_ready_sat),
    .x(x), .w(w), .Z(z_sat), .ZValid(zv_sat), .ZReady(ZReady), .Busy(busy_sat),
    .Overflow(ovf_sat)
  );

  hidden_layer_accum #(.ACC_WIDTH(AWS), .SATURATE(0)) u_wrap (
    .Clk(Clk), .RST(RST), .Start(Start), .InValid(InValid), .InReady(in_ready_wrap),
    .x(x), .w(w), .Z(z_wrap), .ZValid(zv_wrap), .ZReady(ZReady), .Busy(busy_wrap),
    .Overflow(ovf_wrap)
  );

  typedef struct {
    int         w[NN];
    bit         alt;
    int         gaps;
    int         e_def[NN];
    int         e_sat[NN];
    int         e_wrap[NN];
    logic [3:0] o_def;
    logic [3:0] o_sat;
    logic [3:0] o_wrap;
  } vec_t;

  vec_t tbl[4];

  bit beat_x[NI];
  int beat_w[NI][NN];

  logic signed [63:0] exp_def[NN], exp_sat[NN], exp_wrap[NN];
  logic [3:0]         exp_o_def, exp_o_sat, exp_o_wrap;

  task automatic check(input string name, input logic signed [63:0] actual,
                       input logic signed [63:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic logic signed [63:0] lane_def(input int i);
    return $signed(z_def[i*AW +: AW]);
  endfunction

  function automatic logic signed [63:0] lane_sat(input int i);
    return $signed(z_sat[i*AWS +: AWS]);
  endfunction

  function automatic logic signed [63:0] lane_wrap(input int i);
    return $signed(z_wrap[i*AWS +: AWS]);
  endfunction

  function automatic logic [NN*WW-1:0] pack_w(input int b);
    logic [NN*WW-1:0] p;
    p = '0;
    for (int l = 0; l < NN; l++) p[l*WW +: WW] = WW'(beat_w[b][l]);
    return p;
  endfunction

  // Reference: fold the accepted beats of one lane with plain integer
  // arithmetic, applying the clamp or wrap rule whenever the running sum
  // leaves the signed range of 'width' bits.
  function automatic logic signed [63:0] model_lane(input int width, input bit sat,
                                                    input int lane, output logic ov);
    longint acc, hi, lo, span;
    acc  = 0;
    hi   = (longint'(1) << (width - 1)) - 1;
    lo   = -hi - 1;
    span = longint'(1) << width;
    ov   = 1'b0;
    for (int b = 0; b < NI; b++) begin
      if (beat_x[b]) begin
        acc += beat_w[b][lane];
        if (acc > hi) begin
          ov  = 1'b1;
          acc = sat ? hi : acc - span;
        end else if (acc < lo) begin
          ov  = 1'b1;
          acc = sat ? lo : acc + span;
        end
      end
    end
    return acc;
  endfunction

  task automatic model_all();
    logic ov;
    for (int l = 0; l < NN; l++) begin
      exp_def[l]  = model_lane(AW, 1'b1, l, ov);  exp_o_def[l]  = ov;
      exp_sat[l]  = model_lane(AWS, 1'b1, l, ov); exp_o_sat[l]  = ov;
      exp_wrap[l] = model_lane(AWS, 1'b0, l, ov); exp_o_wrap[l] = ov;
    end
  endtask

  // Starts a pass and feeds the NI beats in beat_x/beat_w. gap_mode:
  // 0 = back-to-back, 1 = InValid dropped every third cycle, 2 = random gaps.
  task automatic run_pass(input int gap_mode);
    int  b, cyc;
    bit  gap;
    @(negedge Clk);
    Start = 1'b1; InValid = 1'b0; ZReady = 1'b0;
    @(negedge Clk);
    Start = 1'b0;
    check("start_busy", busy_def, 1);
    check("start_clear", (|z_def) || (|z_sat) || (|z_wrap) || (|ovf_sat) || (|ovf_wrap), 0);
    b = 0; cyc = 0;
    while (b < NI && cyc < 200) begin
      check("accum_inready", in_ready_def, 1);
      check("accum_zvalid", zv_def || zv_sat || zv_wrap, 0);
      if (gap_mode == 1) gap = (cyc % 3 == 2);
      else if (gap_mode == 2) gap = ($urandom_range(0, 3) == 0);
      else gap = 1'b0;
      if (gap) begin
        InValid = 1'b0;
        x = 1'($urandom);
        w = (NN*WW)'({$urandom, $urandom});
      end else begin
        InValid = 1'b1;
        x = beat_x[b];
        w = pack_w(b);
        b++;
      end
      cyc++;
      @(negedge Clk);
    end
    InValid = 1'b0;
    check("hold_zvalid", zv_def && zv_sat && zv_wrap, 1);
    check("hold_inready", in_ready_def, 0);
  endtask

  task automatic check_results();
    for (int l = 0; l < NN; l++) begin
      check($sformatf("z_def[%0d]", l), lane_def(l), exp_def[l]);
      check($sformatf("z_sat[%0d]", l), lane_sat(l), exp_sat[l]);
      check($sformatf("z_wrap[%0d]", l), lane_wrap(l), exp_wrap[l]);
    end
    check("ovf_def", ovf_def, exp_o_def);
    check("ovf_sat", ovf_sat, exp_o_sat);
    check("ovf_wrap", ovf_wrap, exp_o_wrap);
  endtask

  task automatic release_result();
    ZReady = 1'b1;
    @(negedge Clk);
    ZReady = 1'b0;
    check("release_busy", busy_def, 0);
    check("release_zvalid", zv_def, 0);
    check("idle_z_kept", lane_def(0), exp_def[0]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0].w = '{3, -2, 0, 127};     tbl[0].alt = 1'b0; tbl[0].gaps = 0;
    tbl[0].e_def  = '{48, -32, 0, 2032};
    tbl[0].e_sat  = '{48, -32, 0, 255};
    tbl[0].e_wrap = '{48, -32, 0, -16};
    tbl[0].o_def = 4'b0000; tbl[0].o_sat = 4'b1000; tbl[0].o_wrap = 4'b1000;

    tbl[1].w = '{1, 1, 1, 1};        tbl[1].alt = 1'b1; tbl[1].gaps = 1;
    tbl[1].e_def  = '{8, 8, 8, 8};
    tbl[1].e_sat  = '{8, 8, 8, 8};
    tbl[1].e_wrap = '{8, 8, 8, 8};
    tbl[1].o_def = 4'b0000; tbl[1].o_sat = 4'b0000; tbl[1].o_wrap = 4'b0000;

    tbl[2].w = '{-128, -128, 100, -1}; tbl[2].alt = 1'b0; tbl[2].gaps = 0;
    tbl[2].e_def  = '{-2048, -2048, 1600, -16};
    tbl[2].e_sat  = '{-256, -256, 255, -16};
    tbl[2].e_wrap = '{0, 0, 64, -16};
    tbl[2].o_def = 4'b0000; tbl[2].o_sat = 4'b0111; tbl[2].o_wrap = 4'b0111;

    tbl[3].w = '{5, -7, 64, -64};    tbl[3].alt = 1'b1; tbl[3].gaps = 2;
    tbl[3].e_def  = '{40, -56, 512, -512};
    tbl[3].e_sat  = '{40, -56, 255, -256};
    tbl[3].e_wrap = '{40, -56, 0, 0};
    tbl[3].o_def = 4'b0000; tbl[3].o_sat = 4'b1100; tbl[3].o_wrap = 4'b1100;

    // Reset, then InValid without Start must not wake the block.
    RST = 1'b1; Start = 1'b0; InValid = 1'b1; x = 1'b1; ZReady = 1'b0;
    w = (NN*WW)'({$urandom, $urandom});
    repeat (2) @(negedge Clk);
    RST = 1'b0;
    @(negedge Clk);
    check("rst_inready", in_ready_def, 0);
    check("rst_zvalid", zv_def, 0);
    check("rst_z", (|z_def) || (|z_sat) || (|z_wrap), 0);
    check("rst_busy", busy_def, 0);
    check("rst_ovf", (|ovf_def) || (|ovf_sat) || (|ovf_wrap), 0);
    InValid = 1'b0;

    for (int r = 0; r < 4; r++) begin
      for (int b = 0; b < NI; b++) begin
        beat_x[b] = tbl[r].alt ? (b % 2 == 0) : 1'b1;
        for (int l = 0; l < NN; l++) beat_w[b][l] = tbl[r].w[l];
      end
      for (int l = 0; l < NN; l++) begin
        exp_def[l]  = tbl[r].e_def[l];
        exp_sat[l]  = tbl[r].e_sat[l];
        exp_wrap[l] = tbl[r].e_wrap[l];
      end
      exp_o_def = tbl[r].o_def; exp_o_sat = tbl[r].o_sat; exp_o_wrap = tbl[r].o_wrap;
      run_pass(tbl[r].gaps);
      check_results();

      if (r == 0) begin
        // Backpressure: HOLD ignores Start and InValid while ZReady is low.
        for (int k = 0; k < 5; k++) begin
          Start = (k % 2 == 0); InValid = 1'b1; x = 1'b1;
          w = (NN*WW)'({$urandom, $urandom});
          @(negedge Clk);
          check("bp_zvalid", zv_def, 1);
          check("bp_inready", in_ready_def, 0);
          check("bp_z_def", lane_def(3), 2032);
          check("bp_z_sat", lane_sat(3), 255);
          check("bp_z_wrap", lane_wrap(3), -16);
        end
        // ZReady with Start in the same cycle: result taken, Start ignored.
        InValid = 1'b0; Start = 1'b1; ZReady = 1'b1;
        @(negedge Clk);
        Start = 1'b0; ZReady = 1'b0;
        check("take_busy", busy_def, 0);
        check("take_zvalid", zv_def, 0);
        check("take_z_kept", lane_def(0), 48);
        @(negedge Clk);
        check("start_ignored_busy", busy_def, 0);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        check("restart_busy", busy_def, 1);
        check("restart_clear", (|z_def) || (|z_sat) || (|z_wrap), 0);
        check("restart_ovf_clear", (|ovf_sat) || (|ovf_wrap), 0);
        // Abort after 7 beats.
        for (int k = 0; k < 7; k++) begin
          InValid = 1'b1; x = 1'b1; w = {NN{8'd1}};
          @(negedge Clk);
        end
        InValid = 1'b0;
        check("abort_running_z", lane_def(0), 7);
        RST = 1'b1;
        @(negedge Clk);
        RST = 1'b0;
        check("abort_busy", busy_def, 0);
        check("abort_zvalid", zv_def, 0);
        check("abort_z", (|z_def) || (|z_sat) || (|z_wrap), 0);
        check("abort_ovf", (|ovf_def) || (|ovf_sat) || (|ovf_wrap), 0);
        for (int k = 0; k < 20; k++) begin
          InValid = 1'b1; x = 1'b1;
          @(negedge Clk);
          check("abort_no_zvalid", zv_def || busy_def, 0);
        end
        InValid = 1'b0;
      end else begin
        release_result();
      end
    end

    // Random passes against the model, with random consumer delay.
    for (int p = 0; p < 20; p++) begin
      for (int b = 0; b < NI; b++) begin
        beat_x[b] = 1'($urandom);
        for (int l = 0; l < NN; l++) beat_w[b][l] = int'($urandom_range(0, 255)) - 128;
      end
      model_all();
      run_pass(2);
      check_results();
      repeat ($urandom_range(0, 3)) begin
        @(negedge Clk);
        check("rand_hold_zvalid", zv_def, 1);
      end
      release_result();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_hidden_layer_accum
